// File: rtl/mdr_seq_unit_if.sv
// Operand/result bus of the sequential multiply/divide/sqrt unit.
// The driver uses the master modport and the arithmetic unit uses the slave modport.
interface mdr_seq_unit_if #(
   parameter int WORD_LENGTH = 16,
   parameter int OP_WIDTH    = 2
);
   logic                       start;
   logic                       load;
   logic [OP_WIDTH-1:0]        op;
   logic [WORD_LENGTH-1:0]     Data;
   logic                       ready;
   logic                       busy;
   logic                       x;
   logic                       y;
   logic [2*WORD_LENGTH-1:0]   Result;
   logic                       error;

   modport master (
      output start, load, op, Data,
      input  ready, busy, x, y, Result, error
   );

   modport slave (
      input  start, load, op, Data,
      output ready, busy, x, y, Result, error
   );
endinterface

// File: rtl/mdr_seq_unit.sv
// Radix-2 sequential signed multiply, signed divide and unsigned square root.
// Optional build macro MRC_EARLY_EXIT_EN: multiply stops once the remaining multiplier is zero.
module mdr_seq_unit #(
   parameter int WORD_LENGTH = 16,
   parameter int OP_WIDTH    = 2
) (
   input  logic         clk,
   input  logic         reset,
   mdr_seq_unit_if.slave bus
);
   localparam int W  = WORD_LENGTH;
   localparam int CW = $clog2(W + 1);

   localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_DIV  = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_SQRT = OP_WIDTH'(2);
   localparam logic [W-1:0]        MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, RUN, DONE} state_t;

   state_t               state;
   logic                 start_q;
   logic [OP_WIDTH-1:0]  op_q;
   logic                 sign_x;
   logic                 sign_y;
   logic [CW-1:0]        cnt;

   logic signed [W-1:0]  x_q;
   logic [2*W-1:0]       acc;
   logic [2*W-1:0]       aux;
   logic [W-1:0]         sh;

   logic [2*W-1:0]       acc_n;
   logic [2*W-1:0]       aux_n;
   logic [W-1:0]         sh_n;
   logic [2*W-1:0]       rt;
   logic [2*W-1:0]       trial;
   logic [2*W-1:0]       res_n;
   logic                 last_iter;
   logic                 start_acc;
   logic                 div_err;

   function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
      return v[W-1] ? $unsigned(-v) : $unsigned(v);
   endfunction

   function automatic logic [W-1:0] cond_neg_w(input logic n, input logic [W-1:0] v);
      return n ? (~v + W'(1)) : v;
   endfunction

   function automatic logic [2*W-1:0] cond_neg_2w(input logic n, input logic [2*W-1:0] v);
      return n ? (~v + (2*W)'(1)) : v;
   endfunction

   function automatic logic illegal_op(input logic [OP_WIDTH-1:0] o);
      return (o != OP_MUL) && (o != OP_DIV) && (o != OP_SQRT);
   endfunction

   assign start_acc = bus.start & ~start_q;
   assign div_err   = (op_q == OP_DIV) &&
                      ((bus.Data == '0) ||
                       (($unsigned(x_q) == MIN_NEG) && (bus.Data == {W{1'b1}})));

   // acc/aux/sh hold product/multiplicand/multiplier, remainder/divisor/quotient,
   // or remainder/root/radicand depending on the latched op.
   always_comb begin
      acc_n = acc;
      aux_n = aux;
      sh_n  = sh;
      rt    = '0;
      trial = '0;
      res_n = '0;
      case (op_q)
         OP_DIV: begin
            rt = {acc[2*W-2:0], sh[W-1]};
            if (rt >= aux) begin
               acc_n = rt - aux;
               sh_n  = {sh[W-2:0], 1'b1};
            end else begin
               acc_n = rt;
               sh_n  = {sh[W-2:0], 1'b0};
            end
            res_n = {cond_neg_w(sign_x, acc_n[W-1:0]), cond_neg_w(sign_x ^ sign_y, sh_n)};
         end
         OP_SQRT: begin
            rt    = {acc[2*W-3:0], sh[W-1:W-2]};
            trial = {aux[2*W-3:0], 2'b01};
            if (rt >= trial) begin
               acc_n = rt - trial;
               aux_n = {aux[2*W-2:0], 1'b1};
            end else begin
               acc_n = rt;
               aux_n = {aux[2*W-2:0], 1'b0};
            end
            sh_n  = {sh[W-3:0], 2'b00};
            res_n = {acc_n[W-1:0], aux_n[W-1:0]};
         end
         default: begin
            acc_n = acc + (sh[0] ? aux : '0);
            aux_n = {aux[2*W-2:0], 1'b0};
            sh_n  = {1'b0, sh[W-1:1]};
            res_n = cond_neg_2w(sign_x ^ sign_y, acc_n);
         end
      endcase
`ifdef MRC_EARLY_EXIT_EN
      last_iter = (cnt == CW'(1)) || ((op_q == OP_MUL) && (sh_n == '0));
`else
      last_iter = (cnt == CW'(1));
`endif
   end

   // Control FSM with registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         start_q <= 1'b0;
         op_q    <= '0;
         sign_x  <= 1'b0;
         sign_y  <= 1'b0;
         cnt     <= '0;
         bus.ready  <= 1'b0;
         bus.busy   <= 1'b0;
         bus.x      <= 1'b0;
         bus.y      <= 1'b0;
         bus.error  <= 1'b0;
         bus.Result <= '0;
      end else begin
         start_q <= bus.start;
         case (state)
            IDLE, DONE: begin
               if (start_acc) begin
                  op_q      <= bus.op;
                  bus.error <= 1'b0;
                  if (illegal_op(bus.op)) begin
                     state      <= DONE;
                     bus.ready  <= 1'b1;
                     bus.error  <= 1'b1;
                     bus.Result <= '0;
                  end else begin
                     state     <= LOAD_X;
                     bus.ready <= 1'b0;
                     bus.busy  <= 1'b1;
                     bus.x     <= 1'b1;
                  end
               end
            end
            LOAD_X: begin
               if (bus.load) begin
                  sign_x <= bus.Data[W-1];
                  bus.x  <= 1'b0;
                  if (op_q == OP_SQRT) begin
                     state <= RUN;
                     cnt   <= CW'(W / 2);
                  end else begin
                     state <= LOAD_Y;
                     bus.y <= 1'b1;
                  end
               end
            end
            LOAD_Y: begin
               if (bus.load) begin
                  sign_y <= bus.Data[W-1];
                  bus.y  <= 1'b0;
                  if (div_err) begin
                     state      <= DONE;
                     bus.busy   <= 1'b0;
                     bus.ready  <= 1'b1;
                     bus.error  <= 1'b1;
                     bus.Result <= '0;
                  end else begin
                     state <= RUN;
                     cnt   <= CW'(W);
                  end
               end
            end
            RUN: begin
               cnt <= cnt - CW'(1);
               if (last_iter) begin
                  state      <= DONE;
                  bus.busy   <= 1'b0;
                  bus.ready  <= 1'b1;
                  bus.Result <= res_n;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath registers: loaded on operand capture, advanced once per RUN cycle
   always_ff @(posedge clk) begin
      if (state == LOAD_X && bus.load) begin
         x_q <= $signed(bus.Data);
         acc <= '0;
         aux <= '0;
         sh  <= bus.Data;
      end else if (state == LOAD_Y && bus.load) begin
         acc <= '0;
         if (op_q == OP_DIV) begin
            aux <= {{W{1'b0}}, mag($signed(bus.Data))};
            sh  <= mag(x_q);
         end else begin
            aux <= {{W{1'b0}}, mag(x_q)};
            sh  <= mag($signed(bus.Data));
         end
      end else if (state == RUN) begin
         acc <= acc_n;
         aux <= aux_n;
         sh  <= sh_n;
      end
   end
endmodule

// File: tb/tb_mdr_seq_unit.sv
// Scoreboard bench for mdr_seq_unit: directed operations push expected results,
// a negedge monitor compares them whenever ready rises.
module tb_mdr_seq_unit;
   localparam int W = 16;

`ifdef MRC_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      logic [2*W-1:0] res;
      logic           err;
      string          name;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic ready_d = 1'b0;

   mdr_seq_unit_if #(.WORD_LENGTH(W), .OP_WIDTH(2)) bus ();

   mdr_seq_unit #(.WORD_LENGTH(W), .OP_WIDTH(2)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.ready && !ready_d) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ready: got ready=1 with Result %h, required no pending op", bus.Result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_result"}, bus.Result, e.res);
            check({e.name, "_error"}, 32'(bus.error), 32'(e.err));
         end
      end
      ready_d = bus.ready;
   end

   task automatic check_idle_outputs(input string nm);
      check({nm, "_ready"},  32'(bus.ready), 32'd0);
      check({nm, "_busy"},   32'(bus.busy),  32'd0);
      check({nm, "_xy"},     32'({bus.x, bus.y}), 32'd0);
      check({nm, "_error"},  32'(bus.error), 32'd0);
      check({nm, "_Result"}, bus.Result, 32'd0);
   endtask

   task automatic wait_ready(input string nm, input int lat, output int n, output bit saw_y);
      n = 0;
      saw_y = 1'b0;
      while (!bus.ready && n < 200) begin
         @(negedge clk);
         n++;
         if (bus.y) saw_y = 1'b1;
      end
      if (!bus.ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got no ready after %0d cycles, required ready", nm, n);
      end else if (lat >= 0) begin
         check({nm, "_latency"}, 32'(n), 32'(lat));
      end
   endtask

   task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] xv,
                         input logic [W-1:0] yv, input logic [31:0] er, input logic ee,
                         input int lat);
      int n;
      bit saw_y;
      sb.push_back('{res: er, err: ee, name: nm});
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      @(negedge clk);
      bus.start = 1'b0;
      if (o == 2'b11) begin
         check({nm, "_ready_lat"}, 32'(bus.ready), 32'd1);
         return;
      end
      check({nm, "_x"}, 32'(bus.x), 32'd1);
      bus.Data = xv;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      if (o == 2'b10) begin
         check({nm, "_y_low"}, 32'(bus.y), 32'd0);
      end else begin
         check({nm, "_y"}, 32'(bus.y), 32'd1);
         bus.Data = yv;
         bus.load = 1'b1;
         @(negedge clk);
         bus.load = 1'b0;
      end
      wait_ready(nm, lat, n, saw_y);
      if (o == 2'b10) check({nm, "_y_never"}, 32'(saw_y), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   n;
      int   cyc;
      int   held_bad;
      bit   saw_y;
      logic [31:0] held_res;

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.load  = 1'b0;
      bus.op    = 2'b00;
      bus.Data  = '0;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b0;

      run_op("illegal_op",  2'b11, 16'd0,    16'd0,    32'h0000_0000, 1'b1, 0);
      run_op("mul_m200x3",  2'b00, -16'sd200, 16'd3,   32'hFFFF_FDA8, 1'b0, EARLY ? 2 : 16);
      run_op("div_m7d2",    2'b01, -16'sd7,  16'd2,    32'hFFFF_FFFD, 1'b0, 16);
      run_op("sqrt_200",    2'b10, 16'd200,  16'd0,    32'h0004_000E, 1'b0, 8);
      run_op("div_by_zero", 2'b01, 16'd5,    16'd0,    32'h0000_0000, 1'b1, 0);
      run_op("div_ovf",     2'b01, 16'h8000, 16'hFFFF, 32'h0000_0000, 1'b1, 0);
      run_op("mul_min_min", 2'b00, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 16);
      run_op("sqrt_max",    2'b10, 16'hFFFF, 16'd0,    32'h01FE_00FF, 1'b0, 8);
      run_op("div_min_d1",  2'b01, 16'h8000, 16'd1,    32'h0000_8000, 1'b0, 16);
      run_op("mul_by_zero", 2'b00, 16'd1234, 16'd0,    32'h0000_0000, 1'b0, EARLY ? 1 : 16);

      // start held high for 30 cycles across a full multiply
      sb.push_back('{res: 32'hFFFF_FE0C, err: 1'b0, name: "held_mul"});
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b00;
      cyc = 1;
      @(negedge clk);
      cyc++;
      bus.Data = 16'd100;
      bus.load = 1'b1;
      @(negedge clk);
      cyc++;
      bus.Data = -16'sd5;
      @(negedge clk);
      cyc++;
      bus.load = 1'b0;
      wait_ready("held_mul", EARLY ? 3 : 16, n, saw_y);
      cyc += n;
      held_res = 32'hFFFF_FE0C;
      held_bad = 0;
      while (cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (!bus.ready || bus.busy || bus.x || bus.Result !== held_res) held_bad++;
      end
      check("held_done_stable", 32'(held_bad), 32'd0);
      bus.start = 1'b0;
      run_op("restart_div", 2'b01, 16'd100, -16'sd7, 32'h0002_FFF2, 1'b0, 16);

      // reset during RUN cycle 5 of a divide
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b01;
      @(negedge clk);
      bus.start = 1'b0;
      bus.Data  = 16'd1000;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.Data  = 16'd3;
      @(negedge clk);
      bus.load  = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle_outputs("midrun_reset");
      run_op("mul_7xm9", 2'b00, 16'd7, -16'sd9, 32'hFFFF_FFC1, 1'b0, EARLY ? 4 : 16);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mdr_seq_unit.md
Name: mdr_seq_unit

Overview:
- Parametrised sequential arithmetic unit: signed multiply, signed divide and unsigned square root.
- Radix-2, one iteration per clock.
- Operands are loaded serially over a single Data bus using a start/load handshake. x/y indicators tell the driver which operand is expected next.
- Successor to the two-mode MRC datapath: adds divide, mode-dependent latency, overflow/illegal-op error reporting and start edge detection.

Parameters:
- WORD_LENGTH, 16, operand width in bits; must be even and ≥4.
- OP_WIDTH, 2, width of the op selector.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  operation request; sampled and edge-detected internally.
- load  input  1  operand strobe; Data is captured on a clk edge where load=1.
- op  input  OP_WIDTH  00 multiply, 01 divide, 10 sqrt, 11 reserved; latched on the accepted start edge.
- Data  input  WORD_LENGTH  operand bus; two's complement for mul/div, unsigned for sqrt.
- ready  output  1  result valid; held high in DONE.
- busy  output  1  high in LOAD_X, LOAD_Y, RUN.
- x  output  1  high while awaiting operand X.
- y  output  1  high while awaiting operand Y.
- Result  output  2*WORD_LENGTH  result; held stable in DONE until the next accepted start.
- error  output  1  divide-by-zero, divide overflow or illegal op; valid while ready=1.

Behaviour:
- Reset: the clock and reset are as fixed in Already decided. Reset is synchronous and active-high, and applies on any state, including mid-RUN.
  - Next edge: state=IDLE; ready=0, busy=0, x=0, y=0, error=0, Result=0.
  - The start edge register is cleared.
- Start acceptance:
  - Accepted start = start & ~start_q, where start_q is start registered.
  - Honoured only in IDLE or DONE. A start held high for many cycles launches exactly one operation.
- FSM states: IDLE, LOAD_X, LOAD_Y, RUN, DONE.
- IDLE/DONE → on accepted start:
  - Latch op, clear ready and error.
  - If op=11: go to DONE next cycle with error=1 and Result=0.
  - Otherwise go to LOAD_X with x=1.
- LOAD_X, on load: capture X.
  - If op=sqrt: go to RUN.
  - Otherwise: go to LOAD_Y with x=0, y=1.
- LOAD_Y, on load: capture Y, y=0.
  - Divide with Y=0: go to DONE, error=1, Result=0.
  - Divide with X=-2^(W-1) and Y=-1: go to DONE, error=1, Result=0.
  - Otherwise: go to RUN.
- Ignored inputs: load in IDLE, RUN and DONE; start in LOAD_X, LOAD_Y and RUN.
- RUN length:
  - Multiply and divide: exactly WORD_LENGTH cycles.
  - Sqrt: exactly WORD_LENGTH/2 cycles.
  - The iteration counter is loaded on RUN entry. ready rises on the edge after the last iteration.
- Multiply:
  - Shift-add on magnitudes; negate the product if sign(X)≠sign(Y).
  - Result = full 2W-bit signed product; no overflow is possible.
- Divide:
  - Restoring division on magnitudes; truncates toward zero.
  - Result[W-1:0] = quotient.
  - Result[2W-1:W] = remainder, which carries the sign of the dividend (X) or is 0.
- Sqrt:
  - X is unsigned; bit-pair restoring algorithm.
  - Result[W-1:0] = floor(sqrt(X)), zero-extended.
  - Result[2W-1:W] = X − root², zero-extended.
- DONE: ready=1, busy=0. Result and error are held until the next accepted start.

Optional Feature:
- Macro: MRC_EARLY_EXIT_EN.
- Defined: multiply leaves RUN as soon as the right-shifted multiplier magnitude becomes zero after an iteration.
  - Latency = bit-length of |Y|, minimum 1 cycle; |Y|=0 takes 1 cycle.
  - Divide and sqrt latency is unchanged.
- Undefined: fixed WORD_LENGTH-cycle multiply.
- Results are identical in both builds.

Test Plan:
- Multiply, op=00, X=-200, Y=3:
  - Response: Result=32'hFFFFFDA8, error=0.
  - ready rises exactly 16 cycles after the Y load edge.
  - With MRC_EARLY_EXIT_EN, ready rises 2 cycles after the Y load edge.
- Divide, op=01, X=-7, Y=2:
  - Response: Result=32'hFFFFFFFD (remainder -1, quotient -3), error=0, 16 RUN cycles.
- Sqrt, op=10, X=200:
  - Response: Result=32'h0004000E (remainder 4, root 14), 8 RUN cycles.
  - y never asserts.
- Error cases, each giving ready=1, error=1, Result=0:
  - X=5, Y=0 (divide by zero).
  - X=16'h8000, Y=-1 (divide overflow).
  - op=11 (illegal op), with ready one cycle after the start edge.
- start held high for 30 cycles across a complete multiply:
  - Response: exactly one operation; DONE persists with Result held.
  - A second start edge restarts cleanly.
- reset asserted for one cycle at RUN cycle 5 of a divide:
  - Response: all outputs are 0 on the next edge.
  - A following multiply of 7×-9 yields 32'hFFFFFFC1.
